// File: rtl/gcd_engine_param_if.sv
// ---------------------------------------------------------------------------
// gcd_engine_param_if
//   Start/done handshake bundle for gcd_engine_param.
//   master : requester side (drives start/mode/a/b, observes results)
//   slave  : engine side (samples request, drives busy/done/gcd/err/iter)
//   Signals:
//     start  request pulse, sampled only while the engine is idle
//     mode   0 = subtractive Euclid, 1 = binary Stein
//     a, b   operands (WIDTH bits)
//     busy   engine not idle
//     done   result valid strobe (held DONE_CYCLES cycles)
//     gcd    result, err = both operands were zero, iter = CALC cycle count
// ---------------------------------------------------------------------------
interface gcd_engine_param_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] gcd;
  logic             err;
  logic [WIDTH-1:0] iter;

  modport master (
    output start, mode, a, b,
    input  busy, done, gcd, err, iter
  );

  modport slave (
    input  start, mode, a, b,
    output busy, done, gcd, err, iter
  );
endinterface

// File: rtl/gcd_engine_param.sv
// ---------------------------------------------------------------------------
// gcd_engine_param
//   Multi-cycle GCD engine with selectable subtractive Euclid or binary
//   Stein algorithm, zero-operand error flag and a saturating count of the
//   cycles spent computing.
//   Ports:
//     clk    rising-edge clock
//     rst_n  synchronous active-low reset
//     bus    gcd_engine_param_if.slave (request in, registered results out)
//   Parameters:
//     WIDTH        operand/result width (>= 2)
//     DONE_CYCLES  number of cycles done and results are held (>= 1)
// ---------------------------------------------------------------------------
module gcd_engine_param #(
  parameter int WIDTH       = 16,
  parameter int DONE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  gcd_engine_param_if.slave bus
);

  localparam int KW = $clog2(WIDTH) + 1;
  localparam int HW = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] x_q, y_q;
  logic [KW-1:0]    k_q;
  logic             m_q;
  logic [WIDTH-1:0] cnt_q;
  logic [HW-1:0]    hold_q;
  logic             busy_q, done_q, err_q;
  logic [WIDTH-1:0] gcd_q, iter_q;

  // One algorithm step, used only when neither operand is zero.
  logic [WIDTH-1:0] x_d, y_d;
  logic [KW-1:0]    k_d;
  logic [WIDTH-1:0] cnt_inc;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    k_d = k_q;
    if (!m_q) begin
      if (x_q > y_q) x_d = x_q - y_q;
      else           y_d = y_q - x_q;
    end else begin
      if (!x_q[0] && !y_q[0]) begin
        // Common factor of two: remember it in k, re-applied at the end.
        x_d = x_q >> 1;
        y_d = y_q >> 1;
        k_d = k_q + KW'(1);
      end else if (!x_q[0]) begin
        x_d = x_q >> 1;
      end else if (!y_q[0]) begin
        y_d = y_q >> 1;
      end else if (x_q >= y_q) begin
        // Both odd: the difference is even, so halve it right away.
        x_d = (x_q - y_q) >> 1;
      end else begin
        y_d = (y_q - x_q) >> 1;
      end
    end
  end

  // Saturating increment; also gives iter on the terminating cycle.
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + WIDTH'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      k_q     <= '0;
      m_q     <= 1'b0;
      cnt_q   <= '0;
      hold_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      gcd_q   <= '0;
      iter_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            x_q     <= bus.a;
            y_q     <= bus.b;
            m_q     <= bus.mode;
            k_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_CALC;
          end
        end
        S_CALC: begin
          cnt_q <= cnt_inc;
          if ((x_q == '0) || (y_q == '0)) begin
            gcd_q   <= (x_q | y_q) << k_q;
            err_q   <= ((x_q | y_q) == '0);
            iter_q  <= cnt_inc;
            done_q  <= 1'b1;
            hold_q  <= '0;
            state_q <= S_FINISH;
          end else begin
            x_q <= x_d;
            y_q <= y_d;
            k_q <= k_d;
          end
        end
        S_FINISH: begin
          if (hold_q == HW'(DONE_CYCLES - 1)) begin
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            gcd_q   <= '0;
            err_q   <= 1'b0;
            iter_q  <= '0;
            state_q <= S_IDLE;
          end else begin
            hold_q <= hold_q + HW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.gcd  = gcd_q;
  assign bus.err  = err_q;
  assign bus.iter = iter_q;

endmodule

// File: tb/tb_gcd_engine_param.sv
// ---------------------------------------------------------------------------
// tb_gcd_engine_param
//   Checks gcd_engine_param (WIDTH=16 and WIDTH=8 instances) with directed
//   cases and random requests against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_gcd_engine_param;

  localparam int DC    = 2;
  localparam int LIMIT = 5000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  gcd_engine_param_if #(.WIDTH(16)) bus16();
  gcd_engine_param_if #(.WIDTH(8))  bus8();

  gcd_engine_param #(.WIDTH(16), .DONE_CYCLES(DC)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16)
  );

  gcd_engine_param #(.WIDTH(8), .DONE_CYCLES(DC)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model (plain arithmetic) ----------------
  function automatic int gcd_ref(input int x0, input int y0);
    int x = x0, y = y0, t;
    while (y != 0) begin
      t = x % y; x = y; y = t;
    end
    return x;
  endfunction

  // Subtractive Euclid performs exactly one subtraction per unit of each
  // division quotient, plus one terminating cycle.
  function automatic int euclid_iter(input int x0, input int y0, input int width);
    int x = x0, y = y0, t, n = 0, sat;
    sat = (1 << width) - 1;
    if (x == 0 || y == 0) return 1;
    while (y != 0) begin
      n += x / y; t = x % y; x = y; y = t;
    end
    n = n + 1;
    return (n > sat) ? sat : n;
  endfunction

  function automatic int stein_iter(input int x0, input int y0);
    int x = x0, y = y0, n = 0;
    while (x != 0 && y != 0) begin
      n++;
      if (x % 2 == 0 && y % 2 == 0) begin x = x / 2; y = y / 2; end
      else if (x % 2 == 0)          x = x / 2;
      else if (y % 2 == 0)          y = y / 2;
      else if (x >= y)              x = (x - y) / 2;
      else                          y = (y - x) / 2;
    end
    return n + 1;
  endfunction

  // ---------------- request driver for the 16-bit instance ----------------
  task automatic do_req(input logic m, input int av, input int bv, input int glitch_at,
                        output int g, output int e, output int it,
                        output int n, output int dcyc);
    @(negedge clk);
    bus16.start = 1'b1;
    bus16.mode  = m;
    bus16.a     = 16'(av);
    bus16.b     = 16'(bv);
    @(negedge clk);
    bus16.start = 1'b0;
    check_val("busy_after_start", 32'(bus16.busy), 32'd1);
    n = 0;
    while (!bus16.done && n < LIMIT) begin
      n++;
      if (n == glitch_at) begin
        bus16.start = 1'b1;
        bus16.mode  = ~m;
        bus16.a     = 16'd5;
        bus16.b     = 16'd10;
      end else begin
        bus16.start = 1'b0;
      end
      @(negedge clk);
    end
    bus16.start = 1'b0;
    check_val("done_seen", 32'(bus16.done), 32'd1);
    g    = int'(bus16.gcd);
    e    = int'(bus16.err);
    it   = int'(bus16.iter);
    dcyc = 0;
    while (bus16.done && dcyc < LIMIT) begin
      dcyc++;
      @(negedge clk);
    end
    check_val("busy_after_done", 32'(bus16.busy), 32'd0);
    check_val("gcd_idle_zero", 32'(bus16.gcd), 32'd0);
  endtask

  task automatic run_chk(input string tag, input logic m, input int av, input int bv,
                         input int eg, input int ee, input int eit, input int glitch_at);
    int g, e, it, n, dcyc;
    do_req(m, av, bv, glitch_at, g, e, it, n, dcyc);
    $display("req %s mode=%0d a=%0d b=%0d -> gcd=%0d err=%0d iter=%0d calc=%0d done_cyc=%0d",
             tag, m, av, bv, g, e, it, n, dcyc);
    check_val({tag, "_gcd"}, 32'(g), 32'(eg));
    check_val({tag, "_err"}, 32'(e), 32'(ee));
    check_val({tag, "_iter"}, 32'(it), 32'(eit));
    check_val({tag, "_calc_cycles"}, 32'(n), 32'(eit));
    check_val({tag, "_done_cycles"}, 32'(dcyc), 32'(DC));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, dcyc, seen, g8, i8, e8;
    int av, bv, m;

    bus16.start = 1'b1; bus16.mode = 1'b0; bus16.a = 16'd24; bus16.b = 16'd196;
    bus8.start  = 1'b0; bus8.mode  = 1'b0; bus8.a  = 8'd0;   bus8.b  = 8'd0;
    rst_n = 1'b0;

    // Reset held with start high: nothing may start.
    repeat (2) @(negedge clk);
    check_val("rst_busy", 32'(bus16.busy), 32'd0);
    check_val("rst_done", 32'(bus16.done), 32'd0);
    check_val("rst_gcd",  32'(bus16.gcd),  32'd0);
    check_val("rst_err",  32'(bus16.err),  32'd0);
    check_val("rst_iter", 32'(bus16.iter), 32'd0);
    rst_n = 1'b1;
    bus16.start = 1'b0;
    @(negedge clk);
    check_val("rst_no_calc", 32'(bus16.busy), 32'd0);
    $display("reset checked");

    // Directed Euclid
    run_chk("eu_1_1",     1'b0, 1,   1,   1,  0, 2,  -1);
    run_chk("eu_24_196",  1'b0, 24,  196, 4,  0, 15, -1);
    run_chk("eu_128_9",   1'b0, 128, 9,   1,  0, 21, -1);
    run_chk("eu_36_36",   1'b0, 36,  36,  36, 0, 2,  -1);
    // Directed Stein
    run_chk("st_24_196",  1'b1, 24, 196, 4, 0, 10, -1);
    run_chk("st_10000_625", 1'b1, 10000, 625, 625, 0, stein_iter(10000, 625), -1);
    run_chk("eu_10000_625", 1'b0, 10000, 625, 625, 0, euclid_iter(10000, 625, 16), -1);
    // Zero operands
    run_chk("eu_0_7", 1'b0, 0, 7, 7, 0, 1, -1);
    run_chk("st_0_7", 1'b1, 0, 7, 7, 0, 1, -1);
    run_chk("st_7_0", 1'b1, 7, 0, 7, 0, 1, -1);
    run_chk("eu_0_0", 1'b0, 0, 0, 0, 1, 1, -1);
    run_chk("st_0_0", 1'b1, 0, 0, 0, 1, 1, -1);
    // start pulsed mid-CALC must be ignored
    run_chk("glitch", 1'b0, 24, 196, 4, 0, 15, 3);

    // Saturation on the 8-bit instance: 256 CALC cycles, iter saturates at 255
    @(negedge clk);
    bus8.start = 1'b1; bus8.mode = 1'b0; bus8.a = 8'd255; bus8.b = 8'd1;
    @(negedge clk);
    bus8.start = 1'b0;
    n = 0;
    while (!bus8.done && n < LIMIT) begin n++; @(negedge clk); end
    check_val("sat_done_seen", 32'(bus8.done), 32'd1);
    g8 = int'(bus8.gcd); i8 = int'(bus8.iter); e8 = int'(bus8.err);
    dcyc = 0;
    while (bus8.done && dcyc < LIMIT) begin dcyc++; @(negedge clk); end
    $display("req sat8 mode=0 a=255 b=1 -> gcd=%0d err=%0d iter=%0d calc=%0d done_cyc=%0d",
             g8, e8, i8, n, dcyc);
    check_val("sat_gcd",  32'(g8), 32'd1);
    check_val("sat_err",  32'(e8), 32'd0);
    check_val("sat_iter", 32'(i8), 32'(euclid_iter(255, 1, 8)));
    check_val("sat_calc_cycles", 32'(n), 32'd256);
    check_val("sat_done_cycles", 32'(dcyc), 32'(DC));

    // Reset dropped mid-CALC: request discarded, no done
    @(negedge clk);
    bus16.start = 1'b1; bus16.mode = 1'b0; bus16.a = 16'd24; bus16.b = 16'd196;
    @(negedge clk);
    bus16.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_val("midrst_busy", 32'(bus16.busy), 32'd0);
    check_val("midrst_done", 32'(bus16.done), 32'd0);
    check_val("midrst_gcd",  32'(bus16.gcd),  32'd0);
    check_val("midrst_iter", 32'(bus16.iter), 32'd0);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus16.done || bus16.busy) seen++;
    end
    check_val("midrst_no_done", 32'(seen), 32'd0);
    $display("mid-CALC reset checked");
    run_chk("after_rst", 1'b0, 24, 196, 4, 0, 15, -1);

    // Random requests against the model
    for (int r = 0; r < 24; r++) begin
      m = int'($urandom_range(0, 1));
      if (m == 0) begin
        av = int'($urandom_range(0, 300));
        bv = int'($urandom_range(0, 300));
      end else begin
        av = int'($urandom_range(0, 65535));
        bv = int'($urandom_range(0, 65535));
      end
      if (r % 8 == 5) av = 0;
      run_chk("rand", m[0], av, bv, gcd_ref(av, bv), (av == 0 && bv == 0) ? 1 : 0,
              (m == 0) ? euclid_iter(av, bv, 16) : stein_iter(av, bv), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
